// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, word width, default bit period
// and a counter-width helper.
package uart_pkg;

  localparam int unsigned UART_WORD_W       = 10;
  localparam int unsigned UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter with synchronous clear and terminal-count flag.
// Counts up 0..COUNT-1, or down COUNT-1..0 when DOWN is set, then wraps.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned COUNT = UART_CLKS_PER_BIT,
  parameter bit          DOWN  = 1'b0,
  localparam int unsigned W    = cnt_width(COUNT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] FIRST = DOWN ? W'(COUNT - 1) : '0;
  localparam logic [W-1:0] LAST  = DOWN ? '0 : W'(COUNT - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= FIRST;
    end else if (en) begin
      if (tc) begin
        cnt <= FIRST;
      end else if (DOWN) begin
        cnt <= cnt - W'(1);
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one FIFO word per frame and sends
// start bit, DATA_W payload bits LSB first, stop bit on txd.
//
//   state | meaning
//   IDLE  | line at mark, waiting for tx_en and a non-empty FIFO
//   FETCH | one-cycle pop request to the FIFO
//   LOAD  | FIFO read data valid, captured into the shift register
//   START | start bit (space) for one bit period
//   DATA  | payload bits, LSB first
//   STOP  | stop bit (mark); last cycle pulses frame_done and re-arms
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = UART_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = cnt_width(DATA_W);

  localparam logic [IDX_W-1:0]  LAST_BIT = IDX_W'(DATA_W - 1);
  localparam logic [BAUD_W-1:0] PRE_TC   = BAUD_W'(CLKS_PER_BIT - 2);

  tx_state_t          state;
  logic [DATA_W-1:0]  shift_reg;
  logic [IDX_W-1:0]   bit_idx;
  logic [BAUD_W-1:0]  baud_cnt;
  logic               baud_tc;
  logic               baud_clr;

  // The bit period only runs while a bit is on the line.
  assign baud_clr = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_baud_cnt #(
    .COUNT (CLKS_PER_BIT),
    .DOWN  (1'b0)
  ) u_baud_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clr),
    .en    (!baud_clr),
    .cnt   (baud_cnt),
    .tc    (baud_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          txd <= 1'b1;
          if (tx_en && !fifo_empty) begin
            state      <= FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg <= fifo_dout;
          bit_idx   <= '0;
          txd       <= 1'b0;
          state     <= START;
        end
        START: begin
          if (baud_tc) begin
            txd   <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (baud_tc) begin
            if (bit_idx == LAST_BIT) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + IDX_W'(1);
              txd       <= shift_reg[1];
            end
          end
        end
        STOP: begin
          // Registered pulse: raised one cycle early so it lands on the last stop cycle.
          if (baud_cnt == PRE_TC) begin
            frame_done <= 1'b1;
          end
          if (baud_tc) begin
            if (tx_en && !fifo_empty) begin
              state      <= FETCH;
              fifo_rd_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: FIFO model feeds words, a line
// monitor rebuilds frames, and each scenario task compares them against a scoreboard.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int W   = 10;
  localparam int FL  = (W + 2) * CPB;

  typedef struct {
    logic [W-1:0] word;
    bit           shape_ok;
    bit           fd_ok;
    int           start_cyc;
    int           end_cyc;
  } frame_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tx_en = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_rd_en, txd, busy, frame_done;

  logic         rst2 = 1'b1;
  logic         tx_en2 = 1'b1;
  logic         fifo_empty2 = 1'b1;
  logic [W-1:0] fifo_dout2 = '0;
  logic         fifo_rd_en2, txd2, busy2, frame_done2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pops = 0;
  int rd_cycles = 0;
  int bad_pops = 0;
  int fd_stray = 0;
  bit prev_rd = 1'b0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  frame_t       frame_q[$];

  bit          mon_on = 1'b0;
  int          mon_n = 0;
  int          mon_fdcnt = 0;
  int          mon_fdpos = -1;
  bit          mon_busy_bad = 1'b0;
  int          mon_start = 0;
  logic [FL-1:0] samp = '0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(2), .DATA_W(W)) dut_min (
    .clk        (clk),
    .rst        (rst2),
    .tx_en      (tx_en2),
    .fifo_empty (fifo_empty2),
    .fifo_dout  (fifo_dout2),
    .fifo_rd_en (fifo_rd_en2),
    .txd        (txd2),
    .busy       (busy2),
    .frame_done (frame_done2)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // One clock cycle: sample outputs after the edge, advance FIFO model and line monitor.
  task automatic tick();
    frame_t rec;
    @(posedge clk);
    #1;
    cyc++;
    if (fifo_rd_en === 1'b1) begin
      rd_cycles++;
      if (fifo_q.size() == 0) bad_pops++;
    end
    if (prev_rd && fifo_q.size() > 0) begin
      fifo_dout = fifo_q.pop_front();
      pops++;
    end
    prev_rd = (fifo_rd_en === 1'b1);
    fifo_empty = (fifo_q.size() == 0);

    if (!mon_on && txd === 1'b0) begin
      mon_on = 1'b1;
      mon_n = 0;
      mon_fdcnt = 0;
      mon_fdpos = -1;
      mon_busy_bad = 1'b0;
      mon_start = cyc;
      samp = '0;
    end
    if (mon_on) begin
      samp[mon_n] = txd;
      if (busy !== 1'b1) mon_busy_bad = 1'b1;
      if (frame_done === 1'b1) begin
        mon_fdcnt++;
        mon_fdpos = mon_n;
      end
      mon_n++;
      if (mon_n == FL) begin
        rec.shape_ok = (samp[CPB-1:0] == '0) && (samp[FL-1:FL-CPB] == '1) && !mon_busy_bad;
        for (int b = 0; b < W; b++) begin
          rec.word[b] = samp[CPB*(b+1)];
          for (int k = 1; k < CPB; k++)
            if (samp[CPB*(b+1)+k] !== samp[CPB*(b+1)]) rec.shape_ok = 1'b0;
        end
        rec.fd_ok = (mon_fdcnt == 1) && (mon_fdpos == FL - 1);
        rec.start_cyc = mon_start;
        rec.end_cyc = cyc;
        frame_q.push_back(rec);
        mon_on = 1'b0;
        mon_n = 0;
      end
    end else if (frame_done === 1'b1) begin
      fd_stray++;
    end
  endtask

  task automatic queue_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frame_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    int rd_seen = 0;
    int low_seen = 0;
    rst = 1'b1;
    tick();
    tick();
    tests++; if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b required 1", txd); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    rst = 1'b0;
    tx_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_rd_en !== 1'b0) rd_seen++;
      if (txd !== 1'b1) low_seen++;
    end
    tests++; if (rd_seen != 0) begin fails++; $display("FAIL empty_no_pop: got %0d pops required 0", rd_seen); end
    tests++; if (low_seen != 0) begin fails++; $display("FAIL empty_idle_line: got %0d non-mark cycles required 0", low_seen); end
  endtask

  task automatic test_single_frame();
    frame_t r;
    logic [W-1:0] e;
    int drive_cyc;
    int rd0;
    rd0 = rd_cycles;
    queue_word(10'h2A5);
    drive_cyc = cyc;
    wait_frames(1, 200);
    tests++;
    if (frame_q.size() == 0) begin
      fails++; $display("FAIL single_timeout: got 0 frames required 1");
    end else begin
      r = frame_q.pop_front();
      e = exp_q.pop_front();
      tests++; if (r.word !== e) begin fails++; $display("FAIL single_word: got %h required %h", r.word, e); end
      tests++; if (!r.shape_ok) begin fails++; $display("FAIL single_shape: got bad framing required clean %0d-cycle bits", CPB); end
      tests++; if (!r.fd_ok) begin fails++; $display("FAIL single_frame_done: got %0d pulses last at %0d required 1 at %0d", mon_fdcnt, mon_fdpos, FL - 1); end
      tests++; if (r.start_cyc - drive_cyc != 3) begin fails++; $display("FAIL single_start_latency: got %0d required 3", r.start_cyc - drive_cyc); end
    end
    tick();
    tests++; if (rd_cycles - rd0 != 1) begin fails++; $display("FAIL single_rd_pulse: got %0d rd cycles required 1", rd_cycles - rd0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    frame_t r[3];
    logic [W-1:0] e;
    int pops0;
    int rd_late;
    pops0 = pops;
    queue_word(10'h3FF);
    queue_word(10'h000);
    queue_word(10'h155);
    wait_frames(3, 400);
    tests++;
    if (frame_q.size() < 3) begin
      fails++; $display("FAIL b2b_timeout: got %0d frames required 3", frame_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        r[i] = frame_q.pop_front();
        e = exp_q.pop_front();
        tests++; if (r[i].word !== e || !r[i].shape_ok || !r[i].fd_ok) begin
          fails++; $display("FAIL b2b_frame%0d: got %h shape %0d fd %0d required %h clean", i, r[i].word, r[i].shape_ok, r[i].fd_ok, e);
        end
      end
      for (int i = 1; i < 3; i++) begin
        tests++; if (r[i].start_cyc - r[i-1].end_cyc - 1 != 2) begin
          fails++; $display("FAIL b2b_gap%0d: got %0d mark cycles required 2", i, r[i].start_cyc - r[i-1].end_cyc - 1);
        end
      end
    end
    rd_late = rd_cycles;
    for (int i = 0; i < 20; i++) tick();
    tests++; if (pops - pops0 != 3) begin fails++; $display("FAIL b2b_pop_count: got %0d required 3", pops - pops0); end
    tests++; if (rd_cycles != rd_late) begin fails++; $display("FAIL b2b_pop_after_empty: got %0d extra required 0", rd_cycles - rd_late); end
  endtask

  task automatic test_tx_en_drop();
    frame_t r;
    logic [W-1:0] e;
    int pops0;
    int busy_hi = 0;
    queue_word(10'h0C3);
    queue_word(10'h11E);
    for (int i = 0; i < 200 && !(mon_on && mon_n == CPB * 6 + 1); i++) tick();
    tx_en = 1'b0;
    wait_frames(1, 200);
    tests++;
    if (frame_q.size() == 0) begin
      fails++; $display("FAIL en_drop_timeout: got 0 frames required 1");
    end else begin
      r = frame_q.pop_front();
      e = exp_q.pop_front();
      tests++; if (r.word !== e || !r.shape_ok || !r.fd_ok) begin
        fails++; $display("FAIL en_drop_frame: got %h shape %0d fd %0d required %h clean", r.word, r.shape_ok, r.fd_ok, e);
      end
    end
    pops0 = pops;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0) busy_hi++;
    end
    tests++; if (pops != pops0 || busy_hi != 0) begin
      fails++; $display("FAIL en_drop_no_fetch: got %0d pops %0d busy cycles required 0 0", pops - pops0, busy_hi);
    end
    tx_en = 1'b1;
    tick();
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL en_resume_fetch: got %b required 1", fifo_rd_en); end
    wait_frames(1, 200);
    tests++;
    if (frame_q.size() == 0) begin
      fails++; $display("FAIL en_resume_timeout: got 0 frames required 1");
    end else begin
      r = frame_q.pop_front();
      e = exp_q.pop_front();
      tests++; if (r.word !== e || !r.shape_ok) begin fails++; $display("FAIL en_resume_word: got %h required %h", r.word, e); end
    end
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_reset_mid_frame();
    frame_t r;
    logic [W-1:0] e;
    int drive_cyc;
    queue_word(10'h1F0);
    queue_word(10'h2CB);
    for (int i = 0; i < 200 && !(mon_on && mon_n == 20); i++) tick();
    tests++; if (!(mon_on && mon_n == 20)) begin fails++; $display("FAIL rst_mid_reach: got monitor at %0d required 20", mon_n); end
    rst = 1'b1;
    tick();
    tests++; if (txd !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_outputs: got txd %b busy %b rd %b fd %b required 1 0 0 0", txd, busy, fifo_rd_en, frame_done);
    end
    rst = 1'b0;
    mon_on = 1'b0;
    mon_n = 0;
    void'(exp_q.pop_front());
    drive_cyc = cyc;
    wait_frames(1, 200);
    tests++;
    if (frame_q.size() == 0) begin
      fails++; $display("FAIL rst_mid_timeout: got 0 frames required 1");
    end else begin
      r = frame_q.pop_front();
      e = exp_q.pop_front();
      tests++; if (r.word !== e || !r.shape_ok || !r.fd_ok) begin
        fails++; $display("FAIL rst_mid_next_word: got %h shape %0d fd %0d required %h clean", r.word, r.shape_ok, r.fd_ok, e);
      end
      tests++; if (r.start_cyc - drive_cyc != 3) begin fails++; $display("FAIL rst_mid_latency: got %0d required 3", r.start_cyc - drive_cyc); end
    end
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_min_cpb();
    logic [W-1:0] w;
    logic [W-1:0] got;
    logic [W-1:0] e;
    logic [27:0]  s2;
    int start = -1;
    int fdcnt = 0;
    int fdpos = -1;
    int rd_cnt = 0;
    bit prev = 1'b0;
    logic busy_after = 1'b1;
    s2 = '0;
    w = 10'h001;
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    exp_q.push_back(w);
    fifo_empty2 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (fifo_rd_en2 === 1'b1) rd_cnt++;
      if (prev) begin
        fifo_dout2 = w;
        fifo_empty2 = 1'b1;
      end
      prev = (fifo_rd_en2 === 1'b1);
      if (start < 0 && txd2 === 1'b0) start = i;
      if (start >= 0 && i - start < 28) begin
        s2[i - start] = txd2;
        if (frame_done2 === 1'b1) begin fdcnt++; fdpos = i - start; end
        if (i - start == 24) busy_after = busy2;
      end
    end
    e = exp_q.pop_front();
    for (int b = 0; b < W; b++) got[b] = s2[2*(b+1)];
    tests++; if (start < 0) begin fails++; $display("FAIL min_start: got no start bit required one"); end
    tests++; if (got !== e) begin fails++; $display("FAIL min_word: got %h required %h", got, e); end
    tests++; if (s2[4:0] !== 5'b01100) begin fails++; $display("FAIL min_bit0_width: got %b required 01100", s2[4:0]); end
    tests++; if (s2[27:22] !== 6'b111111) begin fails++; $display("FAIL min_stop_mark: got %b required 111111", s2[27:22]); end
    tests++; if (fdcnt != 1 || fdpos != 23) begin fails++; $display("FAIL min_frame_len: got %0d pulses at %0d required 1 at 23", fdcnt, fdpos); end
    tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL min_busy_end: got %b required 0", busy_after); end
    tests++; if (rd_cnt != 1) begin fails++; $display("FAIL min_pop_count: got %0d required 1", rd_cnt); end
  endtask

  task automatic test_global_invariants();
    tests++; if (bad_pops != 0) begin fails++; $display("FAIL pop_while_empty: got %0d required 0", bad_pops); end
    tests++; if (fd_stray != 0) begin fails++; $display("FAIL stray_frame_done: got %0d required 0", fd_stray); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_tx_en_drop();
    test_reset_mid_frame();
    test_min_cpb();
    test_global_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side UART stage sitting directly downstream of the 8-deep, 10-bit transmit FIFO. When the FIFO is not empty, it pops one 10-bit word and shifts it out on `txd` as an asynchronous serial frame. Each frame is one start bit, 10 payload bits LSB first, and one stop bit. Bit period is a fixed number of clock cycles.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `DATA_W`, 10, payload width; must equal FIFO word width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `tx_en`  in  1  enable; when 0, no new frame starts (frame in flight completes).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  DATA_W  FIFO read data; registered in FIFO, valid the cycle after the `fifo_rd_en` cycle.
- `fifo_rd_en`  out  1  single-cycle pop request to FIFO.
- `txd`  out  1  serial line, idle/mark = 1.
- `busy`  out  1  high from FETCH through STOP inclusive.
- `frame_done`  out  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, STOP. All outputs decoded from registered state/flops; no combinational path input→output.
- IDLE: `txd`=1.
  - If `tx_en`=1 and `fifo_empty`=0, go to FETCH.
- FETCH: `fifo_rd_en`=1 for exactly this one cycle; next state LOAD unconditionally.
- LOAD: capture `fifo_dout` into shift register; clear bit counter and baud counter; go to START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `txd`=shift_reg[0]. At the end of each bit period, shift right and increment bit index. After bit `DATA_W-1`'s period, go to STOP.
- STOP: `txd`=1 for `CLKS_PER_BIT` cycles. In its last cycle, `frame_done`=1.
  - Then, if `tx_en`=1 and `fifo_empty`=0, go directly to FETCH.
  - Otherwise go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. Counts 0..`CLKS_PER_BIT-1`; the terminal count ends the bit.
- Bit index: width `$clog2(DATA_W)`; it must not wrap before `DATA_W-1` is reached.
- `fifo_empty` and `tx_en` are sampled only in IDLE and in the last STOP cycle. Changes mid-frame have no effect.
- FIFO `full` is not consumed.
- Reset in any state:
  - Next cycle: state=IDLE, `txd`=1, `busy`=0, `fifo_rd_en`=0, `frame_done`=0, counters=0, shift register=0.
  - A frame cut by reset is abandoned, not resumed. A word already popped is lost.

## Timing
- Reset values: `txd`=1, `busy`=0, `fifo_rd_en`=0, `frame_done`=0.
- Consider IDLE with `fifo_empty` falling, observed at edge E0:
  - FETCH in cycle E0+1 (`fifo_rd_en` high).
  - LOAD in E0+2.
  - `txd` goes low in cycle E0+3.
- Frame length: `(DATA_W+2)*CLKS_PER_BIT` cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
- Back-to-back frames: after the last stop cycle, exactly 2 extra mark cycles (FETCH, LOAD) precede the next start bit.
- `fifo_rd_en` is never asserted while `fifo_empty`=1 at its sampling point. At most one pop per frame.
- `tx_en` dropping mid-frame: the current frame completes, `frame_done` pulses, then the block goes to IDLE.

## Structure
- Shared package `uart_pkg`:
  - state enum `tx_state_t` (IDLE, FETCH, LOAD, START, DATA, STOP);
  - constant `UART_WORD_W = 10`;
  - default `CLKS_PER_BIT` constant.
- One natural sub-module: `uart_baud_cnt`. It is a parameterized down/up counter with a synchronous clear and a terminal-count output. The same counter is reused by the receive-side sampler.
- Top-level FSM, shift register and bit index live in `uart_tx_serializer`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `DATA_W`=10.
- Reset → `txd`=1, `busy`=0, `fifo_rd_en`=0. Hold `fifo_empty`=1 for 100 cycles → `fifo_rd_en` never asserts, `txd` stays 1.
- FIFO model holding 10'h2A5, `fifo_empty` falls → `fifo_rd_en` pulses exactly 1 cycle. `txd` sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1,0,1, 1. `frame_done` pulses once at cycle 48 of the frame.
- Three words 10'h3FF, 10'h000, 10'h155 queued → three frames. Exactly 2 mark cycles between each stop bit and the next start. 3 pops total; no pop after empty.
- `tx_en` deasserted during bit 5 of a frame → the frame completes intact, `frame_done` pulses, and no FETCH follows although `fifo_empty`=0. Re-asserting `tx_en` → FETCH on the next cycle.
- `rst` asserted mid-DATA → next cycle `txd`=1 and state IDLE. With `fifo_empty`=0 afterwards, the next frame starts at E0+3 timing with the next word.
- `CLKS_PER_BIT`=2 (minimum) with word 10'h001 → 24-cycle frame; bit 0 high for exactly 2 cycles.
